// File: rtl/bus_target_mem.sv
// Bus target memory: responds to rq/ack requests inside its address window with a small register file.
// Latency: ack rises ACK_DELAY edges after the first edge that samples rq&&hit, and lasts one cycle.
// Backpressure: the initiator holds rq until ack. Dropping rq during wait states aborts the request. A held rq is acked only once.
module bus_target_mem #(
  parameter int DATA_WIDTH           = 8,
  parameter int ADDR_WIDTH           = 4,
  parameter int ADDR_SPACE_BEGINNING = 0,
  parameter int ADDR_SPACE_END       = 3,
  parameter int ACK_DELAY            = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rq,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] dataR
);

  localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LO  = (ADDR_WIDTH+1)'(ADDR_SPACE_BEGINNING);
  localparam logic [ADDR_WIDTH:0] HI  = (ADDR_WIDTH+1)'(ADDR_SPACE_END);
  localparam logic [3:0]          DLY = 4'(ACK_DELAY);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt;
  logic [IW-1:0]           cap_idx;
  logic                    cap_wr;
  logic [DATA_WIDTH-1:0]   cap_dat;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Window decode: subtractions are done one bit wider so the borrow bit is the out-of-range flag.
  logic [ADDR_WIDTH:0]     off_lo, off_hi;
  logic                    hit;
  logic [IW-1:0]           live_idx;
  assign off_lo   = {1'b0, address} - LO;
  assign off_hi   = HI - {1'b0, address};
  assign hit      = !off_lo[ADDR_WIDTH] && !off_hi[ADDR_WIDTH];
  assign live_idx = off_lo[IW-1:0];

  // With no wait states the operation completes on the accepting edge, so use the live inputs there.
  logic                    accept, enter_ack, op_wr;
  logic [IW-1:0]           op_idx;
  logic [DATA_WIDTH-1:0]   op_dat;
  assign accept    = (state_q == IDLE) && rq && hit;
  assign enter_ack = (state_d == ACK);
  assign op_wr     = (state_q == IDLE) ? wr_ni    : cap_wr;
  assign op_idx    = (state_q == IDLE) ? live_idx : cap_idx;
  assign op_dat    = (state_q == IDLE) ? dataW    : cap_dat;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: full four-phase handshake with abort while waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (DLY == 4'd0) ? ACK : WAIT;
      WAIT: begin
        if (!rq)               state_d = IDLE;
        else if (cnt == 4'd1)  state_d = ACK;
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (!rq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter, storage update and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      cap_idx <= '0;
      cap_wr  <= 1'b0;
      cap_dat <= '0;
      ack     <= 1'b0;
      dataR   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack <= enter_ack;
      if (accept) begin
        cap_idx <= live_idx;
        cap_wr  <= wr_ni;
        cap_dat <= dataW;
        cnt     <= DLY;
      end else if (state_q == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_ack) begin
        if (op_wr) mem[op_idx] <= op_dat;
        else       dataR       <= mem[op_idx];
      end
    end
  end

endmodule

// File: tb/tb_bus_target_mem.sv
// Bench for bus_target_mem: four instances with ACK_DELAY 0/1/3/4 share stimulus; one is selected for checking.
// Expected acks are queued when requests are driven and compared when the selected DUT pulses ack.
// Any ack with an empty queue is flagged as spurious.
module tb_bus_target_mem;

  logic       clk;
  logic       reset;
  logic [3:0] address;
  logic       rq;
  logic       wr_ni;
  logic [7:0] dataW;
  logic       ack_v [4];
  logic [7:0] dr_v  [4];
  logic [1:0] sel;
  logic       ack_sel;
  logic [7:0] dr_sel;
  int         cyc;
  int         n_chk;
  int         n_pass;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mdl [4];
  logic [7:0] last_rd;

  bus_target_mem #(.ACK_DELAY(0)) u_d0 (.clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni), .dataW(dataW), .ack(ack_v[0]), .dataR(dr_v[0]));
  bus_target_mem #(.ACK_DELAY(1)) u_d1 (.clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni), .dataW(dataW), .ack(ack_v[1]), .dataR(dr_v[1]));
  bus_target_mem #(.ACK_DELAY(3)) u_d3 (.clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni), .dataW(dataW), .ack(ack_v[2]), .dataR(dr_v[2]));
  bus_target_mem #(.ACK_DELAY(4)) u_d4 (.clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni), .dataW(dataW), .ack(ack_v[3]), .dataR(dr_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    ack_sel = ack_v[sel];
    dr_sel  = dr_v[sel];
  end

  function automatic int dly_of(input logic [1:0] s);
    case (s)
      2'd0:    return 0;
      2'd1:    return 1;
      2'd2:    return 3;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rq    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    last_rd = 8'h00;
    sb.delete();
  endtask

  // One initiator transaction. acc=1: expect an ack, then keep rq high for 'hold' more cycles.
  // acc=0: expect no ack, hold rq for 'hold' cycles then release.
  task automatic txn(input logic [3:0] a, input bit wr, input logic [7:0] d, input bit acc, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    address = a;
    wr_ni   = wr;
    dataW   = d;
    rq      = 1'b1;
    if (acc) begin
      e.cyc = cyc + 1 + dly_of(sel);
      e.rd  = !wr;
      if (wr) begin
        e.data        = last_rd;
        mdl[a[1:0]]   = d;
      end else begin
        e.data  = mdl[a[1:0]];
        last_rd = mdl[a[1:0]];
      end
      sb.push_back(e);
      @(negedge clk);
      // Inputs after acceptance must be ignored by the target.
      address = a ^ 4'd1;
      dataW   = ~d;
      wr_ni   = ~wr;
      n = 0;
      while (!ack_sel && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("ack_seen", {31'd0, ack_sel}, 32'd1);
      repeat (hold) @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
    end
    rq = 1'b0;
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack_sel) begin
        if (sb.size() == 0) begin
          check("spurious_ack", {31'd0, ack_sel}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", cyc, e.cyc);
          if (e.rd) check("read_data", {24'd0, dr_sel}, {24'd0, e.data});
          else      check("dataR_hold", {24'd0, dr_sel}, {24'd0, e.data});
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc     = 0;
    n_chk   = 0;
    n_pass  = 0;
    reset   = 1'b1;
    rq      = 1'b0;
    wr_ni   = 1'b0;
    address = 4'd0;
    dataW   = 8'd0;
    sel     = 2'd1;
    last_rd = 8'h00;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    fork
      monitor();
    join_none

    // 1: reset state, then reads of every word return zero.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("rst_ack",   {31'd0, ack_v[i]}, 32'd0);
      check("rst_dataR", {24'd0, dr_v[i]},  32'd0);
    end
    for (int i = 0; i < 4; i++) txn(4'(i), 1'b0, 8'h00, 1'b1, 0);

    // 2: ACK_DELAY=1 write then read back.
    txn(4'd2, 1'b1, 8'hA5, 1'b1, 0);
    txn(4'd2, 1'b0, 8'h00, 1'b1, 0);

    // 3: out-of-window request is never acked and leaves storage alone.
    txn(4'd1, 1'b1, 8'h5A, 1'b1, 0);
    txn(4'd9, 1'b1, 8'h77, 1'b0, 20);
    txn(4'd1, 1'b0, 8'h00, 1'b1, 0);
    txn(4'd2, 1'b0, 8'h00, 1'b1, 0);

    // 4: ACK_DELAY=4 abort, then a write whose inputs change during the wait.
    do_reset();
    sel = 2'd3;
    txn(4'd1, 1'b1, 8'h3C, 1'b0, 2);
    txn(4'd1, 1'b0, 8'h00, 1'b1, 0);
    txn(4'd0, 1'b1, 8'h11, 1'b1, 0);
    txn(4'd0, 1'b0, 8'h00, 1'b1, 0);
    txn(4'd1, 1'b0, 8'h00, 1'b1, 0);

    // 5: rq held after ack yields exactly one ack.
    do_reset();
    sel = 2'd1;
    txn(4'd2, 1'b1, 8'h66, 1'b1, 10);
    txn(4'd2, 1'b0, 8'h00, 1'b1, 10);
    txn(4'd3, 1'b0, 8'h00, 1'b1, 0);

    // 6: reset during the wait states of a write (ACK_DELAY=3).
    do_reset();
    sel = 2'd2;
    @(negedge clk);
    address = 4'd3;
    wr_ni   = 1'b1;
    dataW   = 8'hFF;
    rq      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rq    = 1'b0;
    check("midrst_ack",   {31'd0, ack_sel}, 32'd0);
    check("midrst_dataR", {24'd0, dr_sel},  32'd0);
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    last_rd = 8'h00;
    sb.delete();
    @(negedge clk);
    txn(4'd3, 1'b0, 8'h00, 1'b1, 0);

    // 6b: ACK_DELAY=0, ack on the cycle after acceptance.
    do_reset();
    sel = 2'd0;
    txn(4'd3, 1'b1, 8'hFF, 1'b1, 0);
    txn(4'd3, 1'b0, 8'h00, 1'b1, 0);
    txn(4'd0, 1'b0, 8'h00, 1'b1, 3);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
